// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared FSM states, reset-cause bit positions and counter sizing
package rst_seq_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, FAULT} state_t;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_EARLY = 2;
  localparam int CAUSE_SW = 3;
  function automatic int cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/wdt_window_counter.sv
// wdt_window_counter: windowed watchdog count with single-cycle early/timeout fault flags
module wdt_window_counter #(
  parameter int W = 24
) (
  input  logic         clk_sys,
  input  logic         rst_sys,
  input  logic         run,
  input  logic         enable,
  input  logic         kick,
  input  logic         window_en,
  input  logic [W-1:0] cfg_timeout,
  input  logic [W-1:0] cfg_window,
  output logic [W-1:0] wdt_count,
  output logic         early_fault,
  output logic         timeout_fault
);
  logic act;
  assign act = run && enable && (cfg_timeout != '0);
  assign early_fault = act && kick && window_en && (wdt_count < cfg_window);
  // >= so that lowering cfg_timeout below the running count faults at once
  assign timeout_fault = act && !kick && (wdt_count >= cfg_timeout - W'(1));
  always_ff @(posedge clk_sys)
    if (rst_sys || !act || kick || timeout_fault) wdt_count <= '0;
    else wdt_count <= (&wdt_count) ? wdt_count : wdt_count + W'(1);
endmodule

// File: rtl/reset_seq_wdt.sv
// reset_seq_wdt: PLL-gated staggered domain reset release with windowed watchdog and sticky cause
module reset_seq_wdt
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_FILTER = 32,
  parameter int HOLD_CYCLES = 64,
  parameter int WDT_WIDTH = 24
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys,
  input  logic                   pll_locked,
  input  logic                   sw_rst_req,
  input  logic                   wdt_enable,
  input  logic                   wdt_window_en,
  input  logic                   wdt_kick,
  input  logic [WDT_WIDTH-1:0]   cfg_timeout,
  input  logic [WDT_WIDTH-1:0]   cfg_window,
  input  logic                   cause_clr,
  output logic [NUM_DOMAINS-1:0] rst_dom_n,
  output logic                   seq_done,
  output logic                   wdt_reset,
  output logic [WDT_WIDTH-1:0]   wdt_count,
  output logic [3:0]             rst_cause
);
  localparam int REL_LEN = NUM_DOMAINS * STAGE_DELAY;
  localparam int M1 = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int CW = cnt_width((M1 > REL_LEN) ? M1 : REL_LEN);
  state_t st, nxt;
  logic [CW-1:0] cnt, cnt_inc, cnt_nx;
  logic [NUM_DOMAINS-1:0] dom_nx;
  logic [3:0] cause_set;
  logic loss, sw, run_ok, early, tmo;
  assign loss = !pll_locked;
  assign sw = sw_rst_req && (st == RELEASE || st == RUN);
  assign run_ok = (st == RUN) && !loss && !sw;
  assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);
  wdt_window_counter #(.W(WDT_WIDTH)) u_wdt (
    .clk_sys       (clk_sys),
    .rst_sys       (rst_sys),
    .run           (run_ok),
    .enable        (wdt_enable),
    .kick          (wdt_kick),
    .window_en     (wdt_window_en),
    .cfg_timeout   (cfg_timeout),
    .cfg_window    (cfg_window),
    .wdt_count     (wdt_count),
    .early_fault   (early),
    .timeout_fault (tmo)
  );
  always_ff @(posedge clk_sys)
    if (rst_sys) begin
      st        <= HOLD;
      cnt       <= '0;
      rst_dom_n <= '0;
      seq_done  <= 1'b0;
      wdt_reset <= 1'b0;
      rst_cause <= 4'b0001;
    end else begin
      st        <= nxt;
      cnt       <= cnt_nx;
      rst_dom_n <= dom_nx;
      seq_done  <= nxt == RUN;
      wdt_reset <= nxt == FAULT;
      rst_cause <= (cause_clr ? 4'b0 : rst_cause) | cause_set;
    end
  // PLL loss outranks every fault; early/timeout are already masked by run_ok
  always_comb
    nxt = (st != HOLD && loss) ? HOLD :
          (st == HOLD && pll_locked && cnt == CW'(LOCK_FILTER - 1)) ? RELEASE :
          (sw || early || tmo) ? FAULT :
          (st == RELEASE && cnt_inc == CW'(REL_LEN)) ? RUN :
          (st == FAULT && cnt == CW'(HOLD_CYCLES - 1)) ? HOLD : st;
  always_comb begin
    cnt_nx = (nxt != st || st == RUN || (st == HOLD && loss)) ? '0 : cnt_inc;
    cause_set = '0;
    cause_set[CAUSE_POR] = (st != HOLD) && loss;
    cause_set[CAUSE_SW] = sw && !loss;
    cause_set[CAUSE_EARLY] = early;
    cause_set[CAUSE_WDT] = tmo;
  end
  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_dom
    assign dom_nx[k] = (nxt == RUN) || (nxt == RELEASE && cnt_nx >= CW'((k + 1) * STAGE_DELAY));
  end
endmodule
